// File: rtl/apuf_pkg.sv
// Shared types and default sizing for the arbiter-PUF response controller.
package apuf_pkg;
    localparam int LINE_LENGTH_DEF   = 3;
    localparam int NUM_EVAL_DEF      = 7;
    localparam int SETTLE_CYCLES_DEF = 4;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        FIRE,
        SAMPLE,
        DONE
    } state_t;
endpackage

// File: rtl/apuf_response_ctrl_if.sv
// Host-side challenge/response handshake bundle.
interface apuf_response_ctrl_if import apuf_pkg::*; #(
    parameter int LINE_LENGTH = LINE_LENGTH_DEF
);
    logic [LINE_LENGTH-1:0] chal_in;
    logic                   chal_valid;
    logic                   chal_ready;
    logic                   resp_valid;
    logic                   resp_ready;
    logic                   resp_bit;
    logic                   resp_stable;

    modport master (
        output chal_in, chal_valid, resp_ready,
        input  chal_ready, resp_valid, resp_bit, resp_stable
    );

    modport slave (
        input  chal_in, chal_valid, resp_ready,
        output chal_ready, resp_valid, resp_bit, resp_stable
    );
endinterface

// File: rtl/apuf_response_ctrl_arbiter_latch.sv
// Race-winner capture flop (clocked by path 2, data from path 1) plus a
// 2-flop synchronizer; all asynchronous logic lives here.
module arbiter_latch (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_arm,
    input  logic i_d,
    input  logic i_race_clk,
    output logic o_winner
);
    logic r_cap;
    logic r_sync1;
    logic r_sync2;

    // Held clear while launch is low, so every evaluation starts re-armed.
    always_ff @(posedge i_race_clk or negedge i_arm) begin
        if (!i_arm) r_cap <= 1'b0;
        else        r_cap <= i_d;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= r_cap;
            r_sync2 <= r_sync1;
        end
    end

    assign o_winner = r_sync2;
endmodule

// File: rtl/apuf_response_ctrl.sv
// Fires the PUF delay line NUM_EVAL times per challenge and majority-votes
// the captured race winners into one response bit plus a unanimity flag.
module apuf_response_ctrl import apuf_pkg::*; #(
    parameter int LINE_LENGTH   = LINE_LENGTH_DEF,
    parameter int NUM_EVAL      = NUM_EVAL_DEF,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    apuf_response_ctrl_if.slave    host,
    output logic                   line_launch,
    output logic [LINE_LENGTH-1:0] line_challenge,
    input  logic                   line_out_1,
    input  logic                   line_out_2,
    output logic                   busy
);
    localparam int CNT_W = $clog2(NUM_EVAL + 1);
    localparam int PH_W  = $clog2(SETTLE_CYCLES + 2);

    state_t                 r_state, w_state_nxt;
    logic [PH_W-1:0]        r_phase;
    logic [CNT_W-1:0]       r_eval_cnt, r_ones_cnt;
    logic [CNT_W-1:0]       w_eval_inc, w_ones_nxt;
    logic [LINE_LENGTH-1:0] r_chal;
    logic                   r_launch, r_resp_bit, r_resp_stable;
    logic                   w_winner, w_accept, w_last;

    arbiter_latch u_latch (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_arm      (r_launch),
        .i_d        (line_out_1),
        .i_race_clk (line_out_2),
        .o_winner   (w_winner)
    );

    assign w_accept   = host.chal_valid && (r_state == IDLE);
    assign w_eval_inc = r_eval_cnt + CNT_W'(1);
    assign w_ones_nxt = r_ones_cnt + CNT_W'(w_winner);
    assign w_last     = (w_eval_inc == CNT_W'(NUM_EVAL));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // FIRE runs 2 cycles past the settle time to cover synchronizer latency.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (host.chal_valid) w_state_nxt = ARM;
            ARM:     if (r_phase == PH_W'(SETTLE_CYCLES - 1)) w_state_nxt = FIRE;
            FIRE:    if (r_phase == PH_W'(SETTLE_CYCLES + 1)) w_state_nxt = SAMPLE;
            SAMPLE:  w_state_nxt = w_last ? DONE : ARM;
            DONE:    if (host.resp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase       <= '0;
            r_eval_cnt    <= '0;
            r_ones_cnt    <= '0;
            r_chal        <= '0;
            r_launch      <= 1'b0;
            r_resp_bit    <= 1'b0;
            r_resp_stable <= 1'b0;
        end else begin
            // Launch is decoded from next state so the line sees a clean flop output.
            r_launch <= (w_state_nxt == FIRE);
            if (w_state_nxt != r_state)
                r_phase <= '0;
            else if (r_state == ARM || r_state == FIRE)
                r_phase <= r_phase + PH_W'(1);
            if (w_accept) begin
                r_chal     <= host.chal_in;
                r_eval_cnt <= '0;
                r_ones_cnt <= '0;
            end
            if (r_state == SAMPLE) begin
                r_eval_cnt <= w_eval_inc;
                r_ones_cnt <= w_ones_nxt;
                if (w_last) begin
                    r_resp_bit    <= (w_ones_nxt > CNT_W'(NUM_EVAL / 2));
                    r_resp_stable <= (w_ones_nxt == '0) ||
                                     (w_ones_nxt == CNT_W'(NUM_EVAL));
                end
            end
        end
    end

    assign host.chal_ready  = (r_state == IDLE);
    assign host.resp_valid  = (r_state == DONE);
    assign host.resp_bit    = r_resp_bit;
    assign host.resp_stable = r_resp_stable;
    assign line_launch      = r_launch;
    assign line_challenge   = r_chal;
    assign busy             = (r_state != IDLE);
endmodule

// File: tb/tb_apuf_response_ctrl.sv
// Scoreboard bench for apuf_response_ctrl with a behavioural race-line model.
module tb_apuf_response_ctrl;
    import apuf_pkg::*;

    typedef struct {
        logic [2:0] chal;
        logic       rbit;
        logic       rstab;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       line_launch;
    logic [2:0] line_challenge;
    logic       line_out_1 = 1'b0;
    logic       line_out_2 = 1'b0;
    logic       busy;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         npulse = 0;
    int         pulse_base = 0;
    int         t_acc = 0;
    logic [2:0] exp_chal = 3'b000;
    logic [6:0] win_pat = 7'h00;
    bit         stuck = 1'b0;

    always #5 clk = ~clk;

    apuf_response_ctrl_if #(.LINE_LENGTH(3)) host ();

    apuf_response_ctrl #(
        .LINE_LENGTH   (3),
        .NUM_EVAL      (7),
        .SETTLE_CYCLES (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .host           (host),
        .line_launch    (line_launch),
        .line_challenge (line_challenge),
        .line_out_1     (line_out_1),
        .line_out_2     (line_out_2),
        .busy           (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Delay line: the faster path edge arrives 2 ns ahead of the slower one.
    initial begin
        int   idx;
        logic w;
        forever begin
            @(posedge line_launch);
            npulse++;
            chk("line_challenge_at_launch", 32'(line_challenge), 32'(exp_chal));
            idx = npulse - pulse_base - 1;
            w = (idx >= 0 && idx < 7) ? win_pat[idx] : 1'b0;
            if (stuck) begin
                #2 line_out_1 = 1'b1;
            end else if (w) begin
                #2 line_out_1 = 1'b1;
                #2 line_out_2 = 1'b1;
            end else begin
                #2 line_out_2 = 1'b1;
                #2 line_out_1 = 1'b1;
            end
            @(negedge line_launch);
            line_out_1 = 1'b0;
            line_out_2 = 1'b0;
        end
    end

    initial begin
        logic pv;
        exp_t e;
        pv = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv = 1'b0;
                continue;
            end
            if (host.chal_valid && host.chal_ready) begin
                pulse_base = npulse;
                exp_chal   = host.chal_in;
                t_acc      = cyc;
            end
            if (host.resp_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got resp_valid=1 expected no response");
                end else begin
                    e = sb[0];
                    if (!pv) begin
                        chk("latency", 32'(cyc - t_acc - 1), 32'd77);
                        chk("launch_pulses", 32'(npulse - pulse_base), 32'd7);
                        chk("line_challenge_done", 32'(line_challenge), 32'(e.chal));
                    end
                    chk("resp_bit", 32'(host.resp_bit), 32'(e.rbit));
                    chk("resp_stable", 32'(host.resp_stable), 32'(e.rstab));
                    if (!host.resp_ready)
                        chk("chal_ready_backpressure", 32'(host.chal_ready), 32'd0);
                    else
                        void'(sb.pop_front());
                end
            end
            pv = host.resp_valid;
        end
    end

    task automatic issue(input logic [2:0] c, input logic [6:0] pat, input bit stk,
                         input bit push, input logic eb, input logic es);
        exp_t e;
        int   k;
        win_pat = pat;
        stuck   = stk;
        if (push) begin
            e.chal = c;
            e.rbit = eb;
            e.rstab = es;
            sb.push_back(e);
        end
        host.chal_in    = c;
        host.chal_valid = 1'b1;
        k = 0;
        while (!host.chal_ready && k < 200) begin
            tick();
            k++;
        end
        if (k >= 200) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got chal_ready=0 expected 1");
        end
        tick();
        host.chal_valid = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 400) begin
            tick();
            k++;
        end
        if (k >= 400) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        tick();
    endtask

    initial begin
        int   k;
        exp_t e;
        host.chal_valid = 1'b0;
        host.chal_in    = 3'b000;
        host.resp_ready = 1'b1;
        #1 rst_n = 1'b0;
        #5;
        chk("rst_chal_ready", 32'(host.chal_ready), 32'd1);
        chk("rst_line_launch", 32'(line_launch), 32'd0);
        chk("rst_line_challenge", 32'(line_challenge), 32'd0);
        chk("rst_resp_valid", 32'(host.resp_valid), 32'd0);
        chk("rst_resp_bit", 32'(host.resp_bit), 32'd0);
        chk("rst_resp_stable", 32'(host.resp_stable), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        issue(3'b101, 7'h7F, 1'b0, 1'b1, 1'b1, 1'b1);      // path 1 always wins
        wait_done();
        issue(3'b011, 7'h00, 1'b0, 1'b1, 1'b0, 1'b1);      // path 2 always wins
        wait_done();
        issue(3'b001, 7'b0101101, 1'b0, 1'b1, 1'b1, 1'b0); // 1,0,1,1,0,1,0
        wait_done();
        issue(3'b100, 7'b0100101, 1'b0, 1'b1, 1'b0, 1'b0); // 1,0,1,0,0,1,0
        wait_done();
        issue(3'b111, 7'h7F, 1'b1, 1'b1, 1'b0, 1'b1);      // no path-2 edge
        wait_done();

        host.resp_ready = 1'b0;
        issue(3'b110, 7'h7F, 1'b0, 1'b1, 1'b1, 1'b1);
        k = 0;
        while (!host.resp_valid && k < 200) begin
            tick();
            k++;
        end
        if (k >= 200) begin
            checks++;
            errors++;
            $display("FAIL bp_valid_timeout: got resp_valid=0 expected 1");
        end
        e.chal = 3'b010;
        e.rbit = 1'b1;
        e.rstab = 1'b1;
        sb.push_back(e);
        host.chal_in    = 3'b010;
        host.chal_valid = 1'b1;
        repeat (10) tick();
        host.resp_ready = 1'b1;
        tick();
        chk("bp_resp_valid_drop", 32'(host.resp_valid), 32'd0);
        chk("bp_chal_ready_back", 32'(host.chal_ready), 32'd1);
        tick();
        host.chal_valid = 1'b0;
        chk("bp_next_accepted_busy", 32'(busy), 32'd1);
        chk("bp_next_challenge", 32'(line_challenge), 32'd2);
        wait_done();

        issue(3'b100, 7'h7F, 1'b0, 1'b0, 1'b0, 1'b0);
        k = 0;
        while ((npulse - pulse_base) < 3 && k < 200) begin
            tick();
            k++;
        end
        if (k >= 200) begin
            checks++;
            errors++;
            $display("FAIL eval3_timeout: got %0d launches expected 3", npulse - pulse_base);
        end
        repeat (2) tick();
        chk("midfire_launch_high", 32'(line_launch), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_line_launch", 32'(line_launch), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_resp_valid", 32'(host.resp_valid), 32'd0);
        chk("midrst_chal_ready", 32'(host.chal_ready), 32'd1);
        chk("midrst_line_challenge", 32'(line_challenge), 32'd0);
        chk("midrst_resp_bit", 32'(host.resp_bit), 32'd0);
        chk("midrst_resp_stable", 32'(host.resp_stable), 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (100) tick();
        chk("post_rst_chal_ready", 32'(host.chal_ready), 32'd1);
        chk("post_rst_resp_valid", 32'(host.resp_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
